// File: rtl/byte_word_memory_ctl.sv
// Byte-masked word memory with a registered read port and a clear sequencer
// that zeroes every line after reset or when init is pulsed.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | writing zero to line r_clr_cnt each cycle; ready low
// S_IDLE  | accepting one read or write per cycle; ready high
module byte_word_memory_ctl #(
    parameter int WORDBYTES = 4,
    parameter int LINES     = 16,
    parameter int SETBITS   = $clog2(LINES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   init,
    input  logic                   req,
    input  logic                   we,
    input  logic [SETBITS-1:0]     set,
    input  logic [WORDBYTES-1:0]   ByteMask,
    input  logic [8*WORDBYTES-1:0] wd,
    output logic                   ready,
    output logic                   rvalid,
    output logic [8*WORDBYTES-1:0] rd
);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SETBITS-1:0]       r_clr_cnt;
    logic [SETBITS-1:0]       w_clr_cnt_nxt;
    logic [8*WORDBYTES-1:0]   r_mem [LINES];

    logic                     w_accept;
    logic                     w_in_range;
    logic                     w_mem_we;
    logic [SETBITS-1:0]       w_mem_addr;
    logic [WORDBYTES-1:0]     w_mem_mask;
    logic [8*WORDBYTES-1:0]   w_mem_wdata;

    // Non-power-of-two depths leave part of the index space unbacked.
    assign w_in_range = (32'(set) < 32'(LINES));
    assign w_accept   = req & ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        ready         = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_addr    = set;
        w_mem_mask    = ByteMask;
        w_mem_wdata   = wd;
        unique case (r_state)
            S_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_cnt;
                w_mem_mask  = '1;
                w_mem_wdata = '0;
                if (r_clr_cnt == SETBITS'(LINES - 1)) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + SETBITS'(1);
                end
            end
            S_IDLE: begin
                ready    = 1'b1;
                w_mem_we = req & we & w_in_range;
                if (init) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Storage has no reset; only the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < WORDBYTES; b++) begin
                if (w_mem_mask[b]) begin
                    r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= 1'b0;
            rd     <= '0;
        end else begin
            rvalid <= w_accept & ~we;
            if (w_accept && !we) begin
                rd <= w_in_range ? r_mem[set] : '0;
            end
        end
    end

endmodule

// File: tb/tb_byte_word_memory_ctl.sv
// Directed bench for byte_word_memory_ctl: a 16-line instance for the main
// sequences and a 12-line instance for out-of-range set handling.
module tb_byte_word_memory_ctl;

    logic        clk;
    logic        reset_n;
    logic        init, req, we;
    logic [3:0]  set, mask;
    logic [31:0] wd;
    logic        ready, rvalid;
    logic [31:0] rd;

    logic        init12, req12, we12;
    logic [3:0]  set12, mask12;
    logic [31:0] wd12;
    logic        ready12, rvalid12;
    logic [31:0] rd12;

    int n_cmp = 0;
    int n_err = 0;

    byte_word_memory_ctl #(.WORDBYTES(4), .LINES(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .init(init), .req(req), .we(we),
        .set(set), .ByteMask(mask), .wd(wd),
        .ready(ready), .rvalid(rvalid), .rd(rd)
    );

    byte_word_memory_ctl #(.WORDBYTES(4), .LINES(12)) u_dut12 (
        .clk(clk), .reset_n(reset_n), .init(init12), .req(req12), .we(we12),
        .set(set12), .ByteMask(mask12), .wd(wd12),
        .ready(ready12), .rvalid(rvalid12), .rd(rd12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] s, input logic [31:0] d, input logic [3:0] m);
        req = 1'b1; we = 1'b1; set = s; wd = d; mask = m;
        step();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] s, input logic [31:0] exp);
        req = 1'b1; we = 1'b0; set = s;
        step();
        req = 1'b0;
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk(tag, rd, exp);
        step();
        chk({tag, "_rvalid_one"}, 32'(rvalid), 32'd0);
    endtask

    task automatic rd12_chk(input string tag, input logic [3:0] s, input logic [31:0] exp);
        req12 = 1'b1; we12 = 1'b0; set12 = s;
        step();
        req12 = 1'b0;
        chk({tag, "_rvalid"}, 32'(rvalid12), 32'd1);
        chk(tag, rd12, exp);
    endtask

    // After release (or an init edge) ready must stay low for 16 sample points.
    task automatic wait_clear(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_ready_low"}, 32'(ready), 32'd0);
            chk({tag, "_no_rvalid"}, 32'(rvalid), 32'd0);
            step();
        end
        chk({tag, "_ready_high"}, 32'(ready), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        init = 1'b0; req = 1'b0; we = 1'b0; set = '0; mask = '0; wd = '0;
        init12 = 1'b0; req12 = 1'b0; we12 = 1'b0; set12 = '0; mask12 = '0; wd12 = '0;

        step();
        step();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rd", rd, 32'd0);

        // Reset release: both instances clear, 16 and 12 cycles respectively.
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("rel_ready_low", 32'(ready), 32'd0);
            chk("rel_ready12", 32'(ready12), (i >= 12) ? 32'd1 : 32'd0);
            step();
        end
        chk("rel_ready_high", 32'(ready), 32'd1);
        chk("rel_ready12_high", 32'(ready12), 32'd1);

        // Pipelined read of every line: all zero, one response per accept.
        for (int i = 0; i < 16; i++) begin
            req = 1'b1; we = 1'b0; set = 4'(i);
            step();
            chk("sweep_rvalid", 32'(rvalid), 32'd1);
            chk("sweep_rd", rd, 32'd0);
        end
        req = 1'b0;
        step();
        chk("sweep_rvalid_end", 32'(rvalid), 32'd0);

        // Byte masking and the zero-mask no-op.
        wr(4'd3, 32'hAABBCCDD, 4'hF);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd_chk("mask_rd", 4'd3, 32'hAA22CC44);
        wr(4'd3, 32'hFFFFFFFF, 4'h0);
        chk("hold_rd", rd, 32'hAA22CC44);
        rd_chk("mask0_rd", 4'd3, 32'hAA22CC44);

        // Back-to-back write then read of the same set.
        req = 1'b1; we = 1'b1; set = 4'd5; wd = 32'hDEADBEEF; mask = 4'hF;
        step();
        chk("b2b_no_rvalid", 32'(rvalid), 32'd0);
        we = 1'b0;
        step();
        req = 1'b0;
        chk("b2b_rvalid", 32'(rvalid), 32'd1);
        chk("b2b_rd", rd, 32'hDEADBEEF);
        step();
        chk("b2b_rvalid_one", 32'(rvalid), 32'd0);

        // init with a write to set 2; req then held high through the clear.
        wr(4'd4, 32'h0BADF00D, 4'hF);
        init = 1'b1; req = 1'b1; we = 1'b1; set = 4'd2; wd = 32'h12345678; mask = 4'hF;
        step();
        init = 1'b0; set = 4'd4; wd = 32'hFFFFFFFF;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) we = 1'b0;
            chk("clr_ready_low", 32'(ready), 32'd0);
            chk("clr_no_rvalid", 32'(rvalid), 32'd0);
            step();
        end
        req = 1'b0; we = 1'b0;
        chk("clr_ready_high", 32'(ready), 32'd1);
        rd_chk("clr_set2", 4'd2, 32'd0);
        rd_chk("clr_set4", 4'd4, 32'd0);
        rd_chk("clr_set5", 4'd5, 32'd0);
        rd_chk("clr_set3", 4'd3, 32'd0);

        // Reset during a read response: the pending rvalid is lost.
        wr(4'd7, 32'hCAFEF00D, 4'hF);
        req = 1'b1; we = 1'b0; set = 4'd7;
        step();
        req = 1'b0;
        chk("mid_rd_rvalid", 32'(rvalid), 32'd1);
        chk("mid_rd_rd", rd, 32'hCAFEF00D);
        reset_n = 1'b0;
        #1;
        chk("mid_rd_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rd_rst_rd", rd, 32'd0);
        chk("mid_rd_rst_ready", 32'(ready), 32'd0);
        step();
        reset_n = 1'b1;

        // Reset at clear cycle 7: the clear restarts from line 0.
        for (int i = 0; i < 7; i++) step();
        chk("mid_clr_ready", 32'(ready), 32'd0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        wait_clear("rst_clr");
        rd_chk("rst_clr_set7", 4'd7, 32'd0);

        // 12-line instance: out-of-range set drops writes and reads zero.
        req12 = 1'b1; we12 = 1'b1; set12 = 4'd1; wd12 = 32'h01020304; mask12 = 4'hF;
        step();
        set12 = 4'd13; wd12 = 32'h55AA55AA;
        step();
        req12 = 1'b0; we12 = 1'b0;
        rd12_chk("l12_set13", 4'd13, 32'd0);
        rd12_chk("l12_set1", 4'd1, 32'h01020304);
        rd12_chk("l12_set11", 4'd11, 32'd0);
        step();
        chk("l12_rvalid_end", 32'(rvalid12), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
